uart_frame_rx_parser: RTL and testbench

//  Generic byte-stream frame parser that sits between a UART RX core and the ACU/plank/sensor control logic.
//  It delimits frames (header 0xAA, type byte, payload, XOR checksum, footer 0x55) and looks up the

---
 rtl/uart_frame_rx_parser.sv | 203 ++++++++++++++++++++
 tb/tb_uart_frame_rx_parser.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx_parser.sv
// Frame parser AA|type|payload|xor|55: pulses/flags register one cycle after the deciding strobe, rd_data 1-cycle latency.
// No rx backpressure: bytes arriving in HOLD are dropped with o_err_ovr; FRAME_ACK_EN adds a valid/ready ack-byte channel.
module uart_frame_rx_parser #(
    parameter int           MAX_PAYLOAD = 32,
    parameter logic [127:0] LEN_TABLE   = 128'h0000_0000_0000_0000_0000_0001_0012_0500,
    parameter int           TOUT_CYC    = 30000,
    localparam int          AW          = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          i_clk_100,
    input  logic          i_rst_n,
    input  logic          i_rx_dv,
    input  logic [7:0]    i_rx_byte,
    output logic          o_frm_valid,
    output logic [3:0]    o_frm_type,
    output logic [3:0]    o_frm_flags,
    output logic [7:0]    o_frm_len,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    input  logic          i_frm_ack,
    output logic          o_busy,
    output logic          o_err_chk,
    output logic          o_err_ftr,
    output logic          o_err_type,
    output logic          o_err_tout,
    output logic          o_err_ovr,
    output logic [15:0]   o_frm_cnt
`ifdef FRAME_ACK_EN
    ,
    output logic          o_ack_dv,
    output logic [7:0]    o_ack_byte,
    input  logic          i_ack_rdy
`endif
);
    localparam int         TW  = $clog2(TOUT_CYC + 1);
    localparam logic [7:0] HDR = 8'hAA;
    localparam logic [7:0] FTR = 8'h55;

    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_PAY, S_CHK, S_FTR, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    len_q, len_d;
    logic [3:0]    type_q, type_d;
    logic [3:0]    flags_q, flags_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [15:0]   cnt_q;
    logic [7:0]    rd_q;
    logic          valid_q, chk_q, ftr_q, etype_q, tout_err_q, ovr_q;
    logic          ev_ok, ev_chk, ev_ftr, ev_type, ev_tout, ev_ovr;
    logic          wr_en, running, len_ok;
    logic [7:0]    tbl_len;
    logic [7:0]    pay_mem [MAX_PAYLOAD];

    assign running = (state_q == S_TYPE) || (state_q == S_PAY) ||
                     (state_q == S_CHK)  || (state_q == S_FTR);
    assign tbl_len = LEN_TABLE[{i_rx_byte[3:0], 3'b000} +: 8];
    assign len_ok  = (tbl_len != 8'd0) && (int'(tbl_len) <= MAX_PAYLOAD);

    always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            type_q     <= '0;
            flags_q    <= '0;
            tout_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            chk_q      <= 1'b0;
            ftr_q      <= 1'b0;
            etype_q    <= 1'b0;
            tout_err_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            type_q     <= type_d;
            flags_q    <= flags_d;
            tout_q     <= tout_d;
            rd_q       <= pay_mem[i_rd_addr];
            valid_q    <= ev_ok;
            chk_q      <= ev_chk;
            ftr_q      <= ev_ftr;
            etype_q    <= ev_type;
            tout_err_q <= ev_tout;
            ovr_q      <= ev_ovr;
            if (ev_ok) cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk_100) begin
        if (wr_en) pay_mem[idx_q[AW-1:0]] <= i_rx_byte;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        len_d   = len_q;
        type_d  = type_q;
        flags_d = flags_q;
        tout_d  = '0;
        wr_en   = 1'b0;
        ev_ok   = 1'b0;
        ev_chk  = 1'b0;
        ev_ftr  = 1'b0;
        ev_type = 1'b0;
        ev_tout = 1'b0;
        ev_ovr  = 1'b0;
        if (running && !i_rx_dv) tout_d = tout_q + TW'(1);
        case (state_q)
            S_IDLE: if (i_rx_dv && i_rx_byte == HDR) begin
                state_d = S_TYPE;
                acc_d   = HDR;
            end
            S_TYPE: if (i_rx_dv) begin
                if (len_ok) begin
                    state_d = S_PAY;
                    acc_d   = acc_q ^ i_rx_byte;
                    type_d  = i_rx_byte[3:0];
                    flags_d = i_rx_byte[7:4];
                    len_d   = tbl_len;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    ev_type = 1'b1;
                end
            end
            S_PAY: if (i_rx_dv) begin
                wr_en = 1'b1;
                acc_d = acc_q ^ i_rx_byte;
                idx_d = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) state_d = S_CHK;
            end
            S_CHK: if (i_rx_dv) begin
                if (i_rx_byte == acc_q) begin
                    state_d = S_FTR;
                end else begin
                    state_d = S_IDLE;
                    ev_chk  = 1'b1;
                end
            end
            S_FTR: if (i_rx_dv) begin
                state_d = (i_rx_byte == FTR) ? S_HOLD : S_IDLE;
                ev_ok   = (i_rx_byte == FTR);
                ev_ftr  = (i_rx_byte != FTR);
            end
            S_HOLD: begin
                ev_ovr = i_rx_dv;
                if (i_frm_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Counter is cleared by each strobe, so the pulse lands TOUT_CYC cycles after the last strobe cycle.
        if (running && !i_rx_dv && tout_q == TW'(TOUT_CYC - 2)) begin
            state_d = S_IDLE;
            ev_tout = 1'b1;
            tout_d  = '0;
        end
    end

    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_frm_valid = valid_q;
        o_frm_type  = type_q;
        o_frm_flags = flags_q;
        o_frm_len   = len_q;
        o_rd_data   = rd_q;
        o_err_chk   = chk_q;
        o_err_ftr   = ftr_q;
        o_err_type  = etype_q;
        o_err_tout  = tout_err_q;
        o_err_ovr   = ovr_q;
        o_frm_cnt   = cnt_q;
    end

`ifdef FRAME_ACK_EN
    logic       ack_dv_q;
    logic [7:0] ack_byte_q;

    // A fresh event overwrites a pending, unaccepted ack byte.
    always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_dv_q   <= 1'b0;
            ack_byte_q <= '0;
        end else if (ev_ok || ev_chk || ev_ftr) begin
            ack_dv_q   <= 1'b1;
            ack_byte_q <= ev_ok ? 8'hEE : 8'hFF;
        end else if (ack_dv_q && i_ack_rdy) begin
            ack_dv_q   <= 1'b0;
        end
    end

    assign o_ack_dv   = ack_dv_q;
    assign o_ack_byte = ack_byte_q;
`endif

endmodule

// File: tb/tb_uart_frame_rx_parser.sv
// Randomized frame stream checked every cycle against a byte-queue reference model, plus directed literal checks.
module tb_uart_frame_rx_parser;
    localparam int           MAXP = 32;
    localparam logic [127:0] LT   = 128'h0000_0000_0000_0000_0020_2101_0012_0500;
    localparam int           T    = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic       frm_ack = 1'b0;
    logic       o_frm_valid, o_busy, o_err_chk, o_err_ftr, o_err_type, o_err_tout, o_err_ovr;
    logic [3:0] o_frm_type, o_frm_flags;
    logic [7:0] o_frm_len, o_rd_data;
    logic [15:0] o_frm_cnt;
`ifdef FRAME_ACK_EN
    logic       ack_rdy = 1'b0;
    logic       o_ack_dv;
    logic [7:0] o_ack_byte;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit rnd_phase = 0;

    always #5 clk = ~clk;

    uart_frame_rx_parser #(.MAX_PAYLOAD(MAXP), .LEN_TABLE(LT), .TOUT_CYC(T)) dut (
        .i_clk_100(clk), .i_rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
        .o_frm_valid(o_frm_valid), .o_frm_type(o_frm_type), .o_frm_flags(o_frm_flags),
        .o_frm_len(o_frm_len), .i_rd_addr(rd_addr), .o_rd_data(o_rd_data), .i_frm_ack(frm_ack),
        .o_busy(o_busy), .o_err_chk(o_err_chk), .o_err_ftr(o_err_ftr), .o_err_type(o_err_type),
        .o_err_tout(o_err_tout), .o_err_ovr(o_err_ovr), .o_frm_cnt(o_frm_cnt)
`ifdef FRAME_ACK_EN
        , .o_ack_dv(o_ack_dv), .o_ack_byte(o_ack_byte), .i_ack_rdy(ack_rdy)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  frm[$];
    bit          m_hold;
    int          m_len, m_hlen, edge_n, last_dv;
    logic [7:0]  m_hbuf [MAXP];
    bit          e_valid, e_chk, e_ftr, e_etype, e_tout, e_ovr, e_busy, e_rd_chk, e_ack_dv;
    logic [15:0] e_cnt;
    logic [3:0]  e_type, e_flags;
    logic [7:0]  e_len, e_rd, e_ack_byte;

    function automatic int tbl(input logic [3:0] t);
        int l;
        l = int'((LT >> (8 * t)) & 128'hFF);
        return (l > MAXP) ? 0 : l;
    endfunction

    task automatic model_reset();
        frm.delete();
        m_hold = 0; m_len = 0; m_hlen = 0; last_dv = -100000;
        e_valid = 0; e_chk = 0; e_ftr = 0; e_etype = 0; e_tout = 0; e_ovr = 0; e_busy = 0;
        e_cnt = 0; e_type = 0; e_flags = 0; e_len = 0;
        e_rd_chk = 1; e_rd = 0; e_ack_dv = 0; e_ack_byte = 0;
    endtask

    task automatic model_step();
        bit was_hold;
        int n;
        logic [7:0] x;
        was_hold = m_hold;
        e_valid = 0; e_chk = 0; e_ftr = 0; e_etype = 0; e_tout = 0; e_ovr = 0;
        e_rd_chk = 0;
        if (was_hold && int'(rd_addr) < m_hlen) begin
            e_rd_chk = 1;
            e_rd = m_hbuf[rd_addr];
        end
        if (rx_dv) begin
            last_dv = edge_n;
            if (was_hold) e_ovr = 1;
            else if (frm.size() == 0) begin
                if (rx_byte == 8'hAA) frm.push_back(rx_byte);
            end else begin
                frm.push_back(rx_byte);
                n = frm.size();
                if (n == 2) begin
                    m_len = tbl(rx_byte[3:0]);
                    if (m_len == 0) begin
                        e_etype = 1;
                        frm.delete();
                    end else begin
                        e_type = rx_byte[3:0]; e_flags = rx_byte[7:4]; e_len = 8'(m_len);
                    end
                end else if (n == m_len + 3) begin
                    x = 0;
                    for (int i = 0; i < n - 1; i++) x ^= frm[i];
                    if (x != rx_byte) begin
                        e_chk = 1;
                        frm.delete();
                    end
                end else if (n == m_len + 4) begin
                    if (rx_byte == 8'h55) begin
                        e_valid = 1; e_cnt++; m_hold = 1; m_hlen = m_len;
                        for (int i = 0; i < m_len; i++) m_hbuf[i] = frm[2 + i];
                    end else e_ftr = 1;
                    frm.delete();
                end
            end
        end else if (frm.size() > 0 && edge_n == last_dv + T - 1) begin
            e_tout = 1;
            frm.delete();
        end
        if (was_hold && frm_ack) m_hold = 0;
        e_busy = (frm.size() > 0) || m_hold;
`ifdef FRAME_ACK_EN
        if (e_valid) begin e_ack_dv = 1; e_ack_byte = 8'hEE; end
        else if (e_chk || e_ftr) begin e_ack_dv = 1; e_ack_byte = 8'hFF; end
        else if (e_ack_dv && ack_rdy) e_ack_dv = 0;
`endif
    endtask

    task automatic compare();
        check("frm_valid", o_frm_valid, e_valid);
        check("err_chk", o_err_chk, e_chk);
        check("err_ftr", o_err_ftr, e_ftr);
        check("err_type", o_err_type, e_etype);
        check("err_tout", o_err_tout, e_tout);
        check("err_ovr", o_err_ovr, e_ovr);
        check("busy", o_busy, e_busy);
        check("frm_cnt", o_frm_cnt, e_cnt);
        check("frm_type", o_frm_type, e_type);
        check("frm_flags", o_frm_flags, e_flags);
        check("frm_len", o_frm_len, e_len);
        if (e_rd_chk) check("rd_data", o_rd_data, e_rd);
`ifdef FRAME_ACK_EN
        check("ack_dv", o_ack_dv, e_ack_dv);
        check("ack_byte", o_ack_byte, e_ack_byte);
`endif
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset(); else model_step();
            edge_n++;
            @(negedge clk);
            if (!rst_n) model_reset();
            compare();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        rx_dv = 0;
        frm_ack = 0;
        if (rnd_phase) begin
            rd_addr = 5'($urandom);
`ifdef FRAME_ACK_EN
            ack_rdy = 1'($urandom);
`endif
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1;
        rx_byte = b;
        tick();
    endtask

    task automatic send_good_t4();
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11); send_byte(8'hBF); send_byte(8'h55);
    endtask

    task automatic ack_frame();
        frm_ack = 1;
        tick();
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick();
        check(name, o_rd_data, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        #1 rst_n = 0;
        @(posedge clk); #1;
        idle(2);
        rst_n = 1;
        idle(1);
        check("rst_busy", o_busy, 0);
        check("rst_cnt", o_frm_cnt, 0);

        // test 1: stray bytes, then a one-byte sensor frame
        send_byte(8'h13); send_byte(8'h7F);
        check("t1_stray_busy", o_busy, 0);
        send_good_t4();
        check("t1_valid", o_frm_valid, 1);
        check("t1_type", o_frm_type, 4);
        check("t1_flags", o_frm_flags, 0);
        check("t1_len", o_frm_len, 1);
        check("t1_cnt", o_frm_cnt, 1);
`ifdef FRAME_ACK_EN
        check("t1_ack_dv", o_ack_dv, 1);
        check("t1_ack_byte", o_ack_byte, 8'hEE);
`endif
        read_chk("t1_buf0", 5'd0, 8'h11);
        check("t1_valid_pulse", o_frm_valid, 0);
        ack_frame();
        check("t1_released", o_busy, 0);

        // test 2: plank frame with flags E
        send_byte(8'hAA); send_byte(8'hE2);
        repeat (17) send_byte(8'h32);
        send_byte(8'h00); send_byte(8'h7A); send_byte(8'h55);
        check("t2_valid", o_frm_valid, 1);
        check("t2_type", o_frm_type, 2);
        check("t2_flags", o_frm_flags, 4'hE);
        check("t2_len", o_frm_len, 18);
        read_chk("t2_buf0", 5'd0, 8'h32);
        read_chk("t2_buf16", 5'd16, 8'h32);
        read_chk("t2_buf17", 5'd17, 8'h00);
        ack_frame();

        // test 3: bad checksum, trailing footer ignored
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11); send_byte(8'hBE);
        check("t3_err_chk", o_err_chk, 1);
        check("t3_busy", o_busy, 0);
`ifdef FRAME_ACK_EN
        check("t3_ack_byte", o_ack_byte, 8'hFF);
`endif
        send_byte(8'h55);
        check("t3_no_valid", o_frm_valid, 0);
        check("t3_cnt", o_frm_cnt, 2);

        // test 4: timeout after type byte
        send_byte(8'hAA); send_byte(8'h04);
        idle(T - 2);
        check("t4_tout_early", o_err_tout, 0);
        check("t4_busy_early", o_busy, 1);
        idle(1);
        check("t4_tout", o_err_tout, 1);
        check("t4_busy", o_busy, 0);
        send_good_t4();
        check("t4_recover", o_frm_valid, 1);
        ack_frame();

        // test 5: overrun while holding
        rst_n = 0; idle(2); rst_n = 1; idle(1);
        send_good_t4();
        check("t5_cnt1", o_frm_cnt, 1);
        send_byte(8'hAA); check("t5_ovr0", o_err_ovr, 1);
        send_byte(8'h04); check("t5_ovr1", o_err_ovr, 1);
        send_byte(8'h11); check("t5_ovr2", o_err_ovr, 1);
        send_byte(8'hBF); check("t5_ovr3", o_err_ovr, 1);
        send_byte(8'h55); check("t5_ovr4", o_err_ovr, 1);
        check("t5_no_valid", o_frm_valid, 0);
        read_chk("t5_buf0", 5'd0, 8'h11);
        ack_frame();
        send_good_t4();
        check("t5_cnt2", o_frm_cnt, 2);
        ack_frame();

        // table boundaries: 33 exceeds the buffer, 32 fills it
        send_byte(8'hAA); send_byte(8'h05);
        check("len33_err_type", o_err_type, 1);
        x = 8'hAA ^ 8'h06;
        send_byte(8'hAA); send_byte(8'h06);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i * 7));
            x ^= 8'(i * 7);
        end
        send_byte(x); send_byte(8'h55);
        check("len32_valid", o_frm_valid, 1);
        check("len32_len", o_frm_len, 32);
        read_chk("len32_buf31", 5'd31, 8'(31 * 7));
        ack_frame();

        // test 6: reset mid-payload
        send_byte(8'hAA); send_byte(8'hE2);
        repeat (5) send_byte(8'h32);
        rst_n = 0;
        #1;
        check("t6_busy", o_busy, 0);
        check("t6_cnt", o_frm_cnt, 0);
        check("t6_len", o_frm_len, 0);
        check("t6_type", o_frm_type, 0);
        check("t6_flags", o_frm_flags, 0);
        idle(2);
        rst_n = 1;
        idle(1);
        send_good_t4();
        check("t6_valid", o_frm_valid, 1);
        check("t6_cnt1", o_frm_cnt, 1);
        ack_frame();
        send_byte(8'hAA); send_byte(8'h03);
        check("t6_err_type", o_err_type, 1);
        check("t6_idle", o_busy, 0);

        // randomized frame mix
        rnd_phase = 1;
        for (int it = 0; it < 300; it++) begin
            int kind, l, nsend, tpos;
            logic [3:0] t, f;
            logic [7:0] s[$];
            kind = $urandom_range(0, 9);
            f = 4'($urandom);
            case ($urandom_range(0, 3))
                0: t = 4'd1;
                1: t = 4'd2;
                2: t = 4'd4;
                default: t = 4'd6;
            endcase
            if (kind == 8) begin
                t = 4'($urandom);
                if (tbl(t) != 0) t = 4'd3;
            end
            l = tbl(t);
            s.delete();
            s.push_back(8'hAA);
            s.push_back({f, t});
            for (int i = 0; i < l; i++) s.push_back(8'($urandom));
            x = 0;
            foreach (s[i]) x ^= s[i];
            if (kind == 6) x ^= 8'($urandom_range(1, 255));
            s.push_back(x);
            s.push_back((kind == 7) ? (8'h55 ^ 8'($urandom_range(1, 255))) : 8'h55);
            nsend = (kind == 8) ? 2 : s.size();
            tpos = (kind == 9) ? $urandom_range(1, nsend - 1) : -1;
            for (int i = 0; i < nsend; i++) begin
                if (i == tpos) idle(T - 3 + $urandom_range(0, 3));
                else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send_byte(s[i]);
            end
            repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 8'hA9)));
            idle($urandom_range(0, 3));
            ack_frame();
            if (kind == 9) idle(T);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
